// File: rtl/router_link_pkg.sv
// Shared constants and state encoding for the serial router link.
// The transmitter and receiver both import this package so the frame
// format (start pattern, payload width) stays in one place.
package router_link_pkg;

  localparam int DATA_W = 55;                    // payload bits per frame
  localparam int SEQ_W  = 6;                     // start-sequence length
  localparam logic [SEQ_W-1:0] START_SEQ = 6'b01_1111;  // first bit on line = MSB
  localparam int CNT_W  = 6;                     // bit counter, 2**CNT_W > DATA_W

  // Two-bit encoding so the unused codes have a defined recovery path.
  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    RECEIVE = 2'b01
  } rx_state_t;

endpackage

// File: rtl/rx_deframer_seq_detect.sv
// Start-sequence detector: history shift register plus comparator.
// Ports:
//   clk, rst  - clock, async active-high reset
//   en        - shift din into the history this cycle
//   clr       - force history to all ones (wins over en)
//   din       - serial line sample
//   match     - {history, din} equals START_SEQ (combinational)
// Only SEQ_W-1 history bits are stored; the newest bit is the live input,
// so a match is seen on the same edge that samples the last start bit.
module seq_detect
  import router_link_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic match
);

  logic [SEQ_W-2:0] history;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '1;
    end else if (clr) begin
      history <= '1;
    end else if (en) begin
      history <= {history[SEQ_W-3:0], din};
    end
  end

  assign match = ({history, din} == START_SEQ);

endmodule

// File: rtl/rx_deframer.sv
// Serial frame receiver: hunts for the start sequence, deserializes the
// payload MSB first and hands it over with a valid/ack handshake.
// Ports:
//   clk, rst  - clock, async active-high reset
//   S_Data    - serial line, idles at 0, sampled every posedge
//   rx_ack    - consumer acknowledge, clears RX_valid
//   RX_Data   - last complete payload, first received bit at MSB
//   RX_valid  - high from frame completion until acknowledged
//   busy      - high while receiving payload bits
//   overrun   - one-cycle pulse when a frame lands on an unacked word
module rx_deframer
  import router_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              S_Data,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] RX_Data,
  output logic              RX_valid,
  output logic              busy,
  output logic              overrun
);

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  // The final bit comes straight from the line, so only DATA_W-1 bits
  // need to be held here.
  logic [DATA_W-2:0] shreg;
  logic              match;
  logic              last_bit;

  assign last_bit = (state == RECEIVE) && (cnt == CNT_W'(1));

  seq_detect u_seq_detect (
    .clk   (clk),
    .rst   (rst),
    .en    (state == HUNT),
    .clr   (last_bit),
    .din   (S_Data),
    .match (match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      cnt      <= '0;
      shreg    <= '0;
      RX_Data  <= '0;
      RX_valid <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // Completion below overrides this clear, so an ack on the
      // completion edge leaves the new word valid.
      if (rx_ack) RX_valid <= 1'b0;

      case (state)
        HUNT: begin
          if (match) begin
            state <= RECEIVE;
            cnt   <= CNT_W'(DATA_W);
            busy  <= 1'b1;
          end
        end
        RECEIVE: begin
          shreg <= {shreg[DATA_W-3:0], S_Data};
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= HUNT;
            busy     <= 1'b0;
            RX_Data  <= {shreg, S_Data};
            RX_valid <= 1'b1;
            if (RX_valid && !rx_ack) overrun <= 1'b1;
          end
        end
        default: begin
          state <= HUNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_deframer.sv
// Scoreboard bench for rx_deframer: expected words are queued as frames are
// driven and compared when the receiver reports a completed frame.
module tb_rx_deframer;
  import router_link_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              S_Data = 1'b0;
  logic              rx_ack = 1'b0;
  logic [DATA_W-1:0] RX_Data;
  logic              RX_valid;
  logic              busy;
  logic              overrun;

  rx_deframer dut (
    .clk      (clk),
    .rst      (rst),
    .S_Data   (S_Data),
    .rx_ack   (rx_ack),
    .RX_Data  (RX_Data),
    .RX_valid (RX_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              ovr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   completions = 0;
  int   ovr_cycles = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Completion monitor: busy falling marks the edge that latched a frame.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (overrun === 1'b1) ovr_cycles++;
      if (prev_busy && !busy) begin
        completions++;
        if (sb_q.size() == 0) begin
          check("unexpected_frame", 64'(RX_Data), 64'hx);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rx_data",  64'(RX_Data),  64'(e.data));
          check("rx_valid", 64'(RX_valid), 64'd1);
          check("overrun",  64'(overrun),  64'(e.ovr));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      S_Data = 1'b0;
      rx_ack = 1'b0;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    S_Data = 1'b0;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("ack_clears_valid", 64'(RX_valid), 64'd0);
  endtask

  // Drives start sequence then payload MSB first. Input change happens at the
  // negedge, so the posedge after drive k samples bit k.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic ack_last,
                            input logic exp_ovr);
    int berr;
    logic [SEQ_W-1:0] s;
    exp_t e;
    berr = 0;
    s = START_SEQ;
    e.data = d;
    e.ovr = exp_ovr;
    sb_q.push_back(e);
    for (int i = SEQ_W-1; i >= 0; i--) begin
      @(negedge clk);
      if (busy !== 1'b0) berr++;
      S_Data = s[i];
      rx_ack = 1'b0;
    end
    for (int i = DATA_W-1; i >= 0; i--) begin
      @(negedge clk);
      if (busy !== 1'b1) berr++;
      S_Data = d[i];
      rx_ack = (i == 0) ? ack_last : 1'b0;
    end
    @(negedge clk);
    if (busy !== 1'b0) berr++;
    S_Data = 1'b0;
    rx_ack = 1'b0;
    check("busy_window", 64'(berr), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int err;
    int c0;
    int o0;
    logic [5:0] nm;

    repeat (3) @(negedge clk);
    check("reset_data",    64'(RX_Data),  64'd0);
    check("reset_valid",   64'(RX_valid), 64'd0);
    check("reset_busy",    64'(busy),     64'd0);
    check("reset_overrun", 64'(overrun),  64'd0);
    rst = 1'b0;

    // Idle line
    err = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      S_Data = 1'b0;
      if (RX_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) err++;
    end
    check("idle_quiet", 64'(err), 64'd0);

    // Single frame, then ack
    send_frame(55'h2A_5A5A_5A5A_5A5A, 1'b0, 1'b0);
    ack();

    // Payload containing the start pattern
    c0 = completions;
    send_frame(55'h1F_1F1F_1F1F_1F1F, 1'b0, 1'b0);
    idle(70);
    check("false_pattern_one_completion", 64'(completions - c0), 64'd1);
    ack();

    // Overrun: two frames with 2-bit gap, no ack
    o0 = ovr_cycles;
    send_frame(55'h00_0000_0000_0001, 1'b0, 1'b0);
    idle(1);  // send_frame already emits one trailing 0
    send_frame(55'h7F_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    idle(5);
    check("overrun_pulse_count", 64'(ovr_cycles - o0), 64'd1);
    check("overrun_valid_held",  64'(RX_valid), 64'd1);
    check("overrun_data",        64'(RX_Data),  64'h7F_FFFF_FFFF_FFFE);

    // Completion and ack on the same edge: stays valid, no overrun
    send_frame(55'h55_0F0F_3C3C_A5A5, 1'b1, 1'b0);
    idle(3);
    check("same_edge_ack_valid", 64'(RX_valid), 64'd1);
    ack();

    // Near-miss start, then a proper frame (back-to-back, no gap)
    nm = 6'b01_1110;
    err = 0;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      S_Data = nm[i];
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      S_Data = 1'b0;
      if (busy !== 1'b0) err++;
    end
    check("near_miss_no_detect", 64'(err), 64'd0);
    send_frame(55'h33_CCCC_0000_FFFF, 1'b0, 1'b0);
    ack();

    // Reset during data bit 20
    begin
      logic [SEQ_W-1:0] s;
      logic [DATA_W-1:0] d;
      s = START_SEQ;
      d = 55'h6B_DEAD_BEEF_0123;
      send_frame(55'h01_0203_0405_0607, 1'b0, 1'b0);  // leaves RX_Data nonzero
      for (int i = SEQ_W-1; i >= 0; i--) begin
        @(negedge clk);
        S_Data = s[i];
      end
      for (int i = DATA_W-1; i > DATA_W-21; i--) begin
        @(negedge clk);
        S_Data = d[i];
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midreset_data",    64'(RX_Data),  64'd0);
      check("midreset_valid",   64'(RX_valid), 64'd0);
      check("midreset_busy",    64'(busy),     64'd0);
      check("midreset_overrun", 64'(overrun),  64'd0);
      @(negedge clk);
      S_Data = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
    end
    idle(2);
    send_frame(55'h12_3456_789A_BCDE, 1'b0, 1'b0);
    idle(5);
    check("post_reset_data", 64'(RX_Data), 64'h12_3456_789A_BCDE);

    idle(70);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("total_overrun_cycles", 64'(ovr_cycles), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
